// File: rtl/bpm_stab_pkg.sv
// Shared types and helpers for the BPM stabilizer: FSM state encoding,
// median index helper and an unsigned absolute-difference function.
package bpm_stab_pkg;

    localparam int unsigned DEF_W     = 16;
    localparam int unsigned DEF_DEPTH = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FOLD = 3'd1,
        LOAD = 3'd2,
        SORT = 3'd3,
        EMIT = 3'd4
    } state_t;

    // Index of the median element in an ascending window of odd length.
    function automatic int unsigned mid_idx(input int unsigned depth);
        return depth / 32'd2;
    endfunction

    localparam int unsigned MID_IDX = DEF_DEPTH / 32'd2;

    // |a - b| for zero-extended W-bit operands; the magnitude never needs
    // more than W+1 bits, the wider return only keeps callers width-agnostic.
    function automatic logic [32:0] absdiff(input logic [31:0] a, input logic [31:0] b);
        if (a >= b) begin
            return {1'b0, a - b};
        end else begin
            return {1'b0, b - a};
        end
    endfunction

endpackage

// File: rtl/bpm_median_sorter.sv
// Odd-even transposition sorter: one compare-swap pass per cycle,
// alternating even and odd pairs, ascending, unsigned.
// i_load copies a window in, i_start lets passes run, o_done flags the
// cycle whose edge performs the final pass, o_median taps the middle slot.
module bpm_median_sorter
    import bpm_stab_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic                    i_start,
    input  logic [DEPTH-1:0][W-1:0] i_data,
    output logic                    o_done,
    output logic [W-1:0]            o_median
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned MID = mid_idx(DEPTH);

    logic [DEPTH-1:0][W-1:0] r_arr;
    logic [CW-1:0]           r_pass;
    logic [DEPTH-1:0][W-1:0] w_next;
    logic [DEPTH-2:0]        w_swap;

    // Pair k is active on passes whose parity matches k's parity.
    for (genvar k = 0; k < DEPTH - 1; k++) begin : g_swap
        assign w_swap[k] = (1'(k) == r_pass[0]) && (r_arr[k] > r_arr[k+1]);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_next
        if (k == 0) begin : g_first
            assign w_next[k] = w_swap[k] ? r_arr[k+1] : r_arr[k];
        end else if (k == DEPTH - 1) begin : g_last
            assign w_next[k] = w_swap[k-1] ? r_arr[k-1] : r_arr[k];
        end else begin : g_mid
            assign w_next[k] = w_swap[k]   ? r_arr[k+1] :
                               w_swap[k-1] ? r_arr[k-1] : r_arr[k];
        end
    end

    // Load a fresh window or advance the sort by one pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arr  <= '0;
            r_pass <= '0;
        end else if (i_load) begin
            r_arr  <= i_data;
            r_pass <= '0;
        end else if (i_start && (r_pass < CW'(DEPTH))) begin
            r_arr  <= w_next;
            r_pass <= r_pass + CW'(1);
        end
    end

    assign o_done   = i_start && (r_pass == CW'(DEPTH - 1));
    assign o_median = r_arr[MID];

endmodule

// File: rtl/bpm_stabilizer.sv
// BPM stabilizer: range-gates raw BPM estimates, median-filters the last
// DEPTH accepted samples and emits the result over valid/ready together
// with locked/stale status and a saturating reject counter.
// Optional half/double-tempo folding is enabled by BPM_STAB_OCTAVE_FIX_EN.
module bpm_stabilizer
    import bpm_stab_pkg::*;
#(
    parameter int unsigned W              = 16,
    parameter int unsigned DEPTH          = 5,
    parameter int unsigned MIN_BPM        = 40,
    parameter int unsigned MAX_BPM        = 240,
    parameter int unsigned LOCK_TOL       = 3,
    parameter int unsigned LOCK_COUNT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] bpm_in,
    input  logic         bpm_in_valid,
    output logic         bpm_in_ready,
    output logic [W-1:0] bpm_out,
    output logic         bpm_out_valid,
    input  logic         bpm_out_ready,
    output logic         locked,
    output logic         stale,
    output logic [7:0]   reject_count
);

    if ((DEPTH < 3) || ((DEPTH % 2) == 0)) begin : g_depth_check
        $error("bpm_stabilizer: DEPTH must be odd and at least 3");
    end

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam int unsigned LW = $clog2(LOCK_COUNT + 1);

    state_t                  r_state;
    logic [DEPTH-1:0][W-1:0] r_ring;
    logic [PW-1:0]           r_wptr;
    logic [FW-1:0]           r_fill;
    logic [W-1:0]            r_newest;
    logic [LW-1:0]           r_lock_cnt;
    logic [31:0]             r_to_cnt;
    logic                    r_in_ready;
    logic [W-1:0]            r_bpm_out;
    logic                    r_out_valid;
    logic                    r_locked;
    logic                    r_stale;
    logic [7:0]              r_reject;

    logic                    w_in_range;
    logic                    w_accept;
    logic                    w_timeout_hit;
    logic                    w_sort_done;
    logic [W-1:0]            w_median;
    logic                    w_agree;
    logic [LW-1:0]           w_lock_cnt_next;

    assign w_in_range    = (bpm_in >= W'(MIN_BPM)) && (bpm_in <= W'(MAX_BPM));
    assign w_accept      = (r_state == IDLE) && bpm_in_valid && w_in_range;
    // An accept on the same edge restarts the timer, so it beats the flush.
    assign w_timeout_hit = (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) && !w_accept;
    assign w_agree       = absdiff(32'(w_median), 32'(r_bpm_out)) <= 33'(LOCK_TOL);

    bpm_median_sorter #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_sorter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (r_state == LOAD),
        .i_start  (r_state == SORT),
        .i_data   (r_ring),
        .o_done   (w_sort_done),
        .o_median (w_median)
    );

    // Next lock-streak count if the new median agrees with the last output.
    always_comb begin
        w_lock_cnt_next = '0;
        if (w_agree) begin
            w_lock_cnt_next = (r_lock_cnt == LW'(LOCK_COUNT)) ? r_lock_cnt
                                                              : r_lock_cnt + LW'(1);
        end else begin
            w_lock_cnt_next = '0;
        end
    end

`ifdef BPM_STAB_OCTAVE_FIX_EN
    logic [PW-1:0] r_last_ptr;
    logic [W-1:0]  w_fold;
    logic [W:0]    w_dbl;

    assign w_dbl = {r_newest, 1'b0};

    // Fold half/double-tempo samples toward the locked median (last output).
    always_comb begin
        w_fold = r_newest;
        if (r_locked && (r_fill == FW'(DEPTH))) begin
            if (absdiff(32'(r_newest), 32'(r_bpm_out) << 1) <= 33'(2 * LOCK_TOL)) begin
                w_fold = r_newest >> 1;
            end else if (absdiff(32'(w_dbl), 32'(r_bpm_out)) <= 33'(2 * LOCK_TOL)) begin
                w_fold = (w_dbl > (W+1)'(MAX_BPM)) ? W'(MAX_BPM) : w_dbl[W-1:0];
            end else begin
                w_fold = r_newest;
            end
        end else begin
            w_fold = r_newest;
        end
    end
`endif

    // Main FSM: accept/gate, sort sequencing, emit handshake, lock and timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ring      <= '0;
            r_wptr      <= '0;
            r_fill      <= '0;
            r_newest    <= '0;
            r_lock_cnt  <= '0;
            r_to_cnt    <= 32'd0;
            r_in_ready  <= 1'b1;
            r_bpm_out   <= '0;
            r_out_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_stale     <= 1'b0;
            r_reject    <= 8'd0;
`ifdef BPM_STAB_OCTAVE_FIX_EN
            r_last_ptr  <= '0;
`endif
        end else begin
            if (r_to_cnt < 32'(TIMEOUT_CYCLES)) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end

            case (r_state)
                IDLE: begin
                    if (bpm_in_valid) begin
                        if (w_in_range) begin
                            r_ring[r_wptr] <= bpm_in;
                            r_newest       <= bpm_in;
                            r_wptr         <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
                            r_fill         <= (r_fill == FW'(DEPTH)) ? r_fill : r_fill + FW'(1);
                            r_to_cnt       <= 32'd0;
                            r_stale        <= 1'b0;
                            r_in_ready     <= 1'b0;
`ifdef BPM_STAB_OCTAVE_FIX_EN
                            r_last_ptr     <= r_wptr;
                            r_state        <= FOLD;
`else
                            r_state        <= LOAD;
`endif
                        end else if (r_reject != 8'hFF) begin
                            r_reject <= r_reject + 8'd1;
                        end
                    end
                end
`ifdef BPM_STAB_OCTAVE_FIX_EN
                FOLD: begin
                    r_ring[r_last_ptr] <= w_fold;
                    r_newest           <= w_fold;
                    r_state            <= LOAD;
                end
`endif
                LOAD: begin
                    r_state <= SORT;
                end
                SORT: begin
                    if (w_sort_done) begin
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (!r_out_valid) begin
                        if (r_fill == FW'(DEPTH)) begin
                            r_bpm_out  <= w_median;
                            r_lock_cnt <= w_lock_cnt_next;
                            r_locked   <= (w_lock_cnt_next == LW'(LOCK_COUNT));
                        end else begin
                            r_bpm_out  <= r_newest;
                        end
                        r_out_valid <= 1'b1;
                    end else if (bpm_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase

            if (w_timeout_hit) begin
                r_stale    <= 1'b1;
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
                r_fill     <= '0;
                r_wptr     <= '0;
            end
        end
    end

    assign bpm_in_ready  = r_in_ready;
    assign bpm_out       = r_bpm_out;
    assign bpm_out_valid = r_out_valid;
    assign locked        = r_locked;
    assign stale         = r_stale;
    assign reject_count  = r_reject;

endmodule

// File: tb/tb_bpm_stabilizer.sv
// Self-checking bench for bpm_stabilizer: directed scenarios plus random
// traffic, checked every cycle against a transaction-level model.
module tb_bpm_stabilizer;

    localparam int DEPTH = 5;
    localparam int TOL   = 3;
    localparam int LCNT  = 4;
    localparam int TMO   = 1000;
`ifdef BPM_STAB_OCTAVE_FIX_EN
    localparam int LAT   = DEPTH + 3;
`else
    localparam int LAT   = DEPTH + 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bpm_in = 16'd0;
    logic        bpm_in_valid = 1'b0;
    logic        bpm_in_ready;
    logic [15:0] bpm_out;
    logic        bpm_out_valid;
    logic        bpm_out_ready = 1'b1;
    logic        locked;
    logic        stale;
    logic [7:0]  reject_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 0;

    // Model state
    int hist[$];
    int m_out = 0, m_newest = 0, m_rej = 0, m_lockcnt = 0, m_since = 0, m_phase = 0;
    bit m_in_ready = 1, m_valid = 0, m_locked = 0, m_stale = 0;

    always #5 clk = ~clk;

    bpm_stabilizer #(
        .W(16), .DEPTH(DEPTH), .MIN_BPM(40), .MAX_BPM(240),
        .LOCK_TOL(TOL), .LOCK_COUNT(LCNT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .bpm_in(bpm_in), .bpm_in_valid(bpm_in_valid), .bpm_in_ready(bpm_in_ready),
        .bpm_out(bpm_out), .bpm_out_valid(bpm_out_valid), .bpm_out_ready(bpm_out_ready),
        .locked(locked), .stale(stale), .reject_count(reject_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Transaction-level model advanced once per rising edge.
    task automatic model_step();
        int s;
        int med;
        int tmp[$];
        bit acc;
        cyc++;
        if (reset) begin
            hist.delete();
            m_out = 0; m_newest = 0; m_rej = 0; m_lockcnt = 0; m_since = 0; m_phase = 0;
            m_in_ready = 1; m_valid = 0; m_locked = 0; m_stale = 0;
            return;
        end
        acc = 0;
        if (m_in_ready) begin
            if (bpm_in_valid) begin
                s = int'(bpm_in);
                if (s >= 40 && s <= 240) begin
                    acc = 1;
`ifdef BPM_STAB_OCTAVE_FIX_EN
                    if (m_locked && hist.size() == DEPTH) begin
                        if (iabs(s - 2 * m_out) <= 2 * TOL) s = s / 2;
                        else if (iabs(2 * s - m_out) <= 2 * TOL) s = (2 * s > 240) ? 240 : 2 * s;
                    end
`endif
                    hist.push_back(s);
                    if (hist.size() > DEPTH) void'(hist.pop_front());
                    m_newest = s; m_in_ready = 0; m_stale = 0; m_phase = 0; m_since = 0;
                end else if (m_rej < 255) begin
                    m_rej++;
                end
            end
        end else begin
            m_phase++;
            if (m_phase == LAT) begin
                if (hist.size() == DEPTH) begin
                    tmp = hist;
                    tmp.sort();
                    med = tmp[DEPTH / 2];
                    if (iabs(med - m_out) <= TOL) begin
                        if (m_lockcnt < LCNT) m_lockcnt++;
                        m_locked = (m_lockcnt == LCNT);
                    end else begin
                        m_lockcnt = 0; m_locked = 0;
                    end
                    m_out = med;
                end else begin
                    m_out = m_newest;
                end
                m_valid = 1;
            end else if (m_phase > LAT && bpm_out_ready) begin
                m_valid = 0; m_in_ready = 1;
            end
        end
        if (!acc && m_since < TMO) begin
            m_since++;
            if (m_since == TMO) begin
                m_stale = 1; m_locked = 0; m_lockcnt = 0; hist.delete();
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("in_ready", int'(bpm_in_ready), int'(m_in_ready));
            chk("out_valid", int'(bpm_out_valid), int'(m_valid));
            chk("bpm_out", int'(bpm_out), m_out);
            chk("locked", int'(locked), int'(m_locked));
            chk("stale", int'(stale), int'(m_stale));
            chk("reject_count", int'(reject_count), m_rej);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bpm_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(bpm_in_ready), 1);
    endtask

    // Offer one sample, check latency and the emitted value.
    task automatic send(input int s, input int exp_out);
        int acc_cyc;
        int n = 0;
        wait_ready();
        bpm_in = 16'(s);
        bpm_in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        bpm_in_valid = 1'b0;
        while (!bpm_out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("latency", cyc - acc_cyc, LAT);
        chk("value", int'(bpm_out), exp_out);
    endtask

    task automatic check_reset_values();
        chk("rst_bpm_out", int'(bpm_out), 0);
        chk("rst_out_valid", int'(bpm_out_valid), 0);
        chk("rst_in_ready", int'(bpm_in_ready), 1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_stale", int'(stale), 0);
        chk("rst_reject", int'(reject_count), 0);
    endtask

    initial begin
        int acc_cyc;
        int n;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        chk_en = 1;

        // Steady 120s: passthrough while filling, lock after 4 full windows.
        for (int i = 0; i < 8; i++) begin
            send(120, 120);
            if (i == 6) chk("locked_after_3_full", int'(locked), 0);
        end
        chk("locked_after_4_full", int'(locked), 1);

        // Single outlier is removed by the median.
        send(200, 120);
        chk("locked_outlier", int'(locked), 1);

        // Out-of-range samples are only counted.
        wait_ready();
        bpm_in = 16'd30; bpm_in_valid = 1'b1;
        @(negedge clk);
        bpm_in = 16'd250;
        @(negedge clk);
        bpm_in_valid = 1'b0;
        chk("reject_two", int'(reject_count), 2);
        chk("reject_ready", int'(bpm_in_ready), 1);
        chk("reject_no_out", int'(bpm_out_valid), 0);

        // Backpressure: output held, new sample waits for EMIT to finish.
        bpm_out_ready = 1'b0;
        send(121, 120);
        bpm_in = 16'd122; bpm_in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_ready_low", int'(bpm_in_ready), 0);
            chk("bp_out_hold", int'(bpm_out), 120);
        end
        bpm_out_ready = 1'b1;
        n = 0;
        while (!bpm_in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        bpm_in_valid = 1'b0;
        n = 0;
        while (!bpm_out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", cyc - acc_cyc, LAT);
        chk("bp_value", int'(bpm_out), 121);

        // Timeout: stale raised, lock dropped, window flushed.
        repeat (1100) @(negedge clk);
        chk("timeout_stale", int'(stale), 1);
        chk("timeout_locked", int'(locked), 0);
        send(90, 90);
        chk("stale_cleared", int'(stale), 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            bpm_out_ready = (($urandom % 4) != 0);
            bpm_in_valid  = (($urandom % 3) == 0);
            if (($urandom % 10) < 7) bpm_in = 16'(98 + $urandom_range(0, 4));
            else bpm_in = 16'($urandom_range(20, 260));
        end
        bpm_in_valid = 1'b0;
        bpm_out_ready = 1'b1;
        repeat (40) @(negedge clk);

        // Reset asserted while sorting.
        wait_ready();
        bpm_in = 16'd100; bpm_in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        bpm_in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
